// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared sizing constants for the RV32 integer register file
package reg_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  // x0 index; reads of it are forced to zero and writes to it are dropped
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_read_port.sv
// rtl/reg_file_read_port.sv - combinational read mux with x0 zeroing; optional REG_FILE_BYPASS_EN forwarding
module reg_file_read_port #(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH
) (
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]                      addr,
  input  logic                                       reset,
  input  logic                                       write_enable,
  input  logic [ADDR_WIDTH-1:0]                      write_address,
  input  logic [DATA_WIDTH-1:0]                      write_data,
  output logic [DATA_WIDTH-1:0]                      data
);
  import reg_file_pkg::*;

  logic addr_is_zero;
  assign addr_is_zero = (addr == ADDR_WIDTH'(REG_ZERO));

`ifdef REG_FILE_BYPASS_EN
  // Forward the writeback value in the same cycle; never for x0 or during reset
  logic bypass_hit;
  assign bypass_hit = !reset && write_enable && !addr_is_zero &&
                      (write_address == addr);

  always_comb begin
    data = '0;
    if (bypass_hit)
      data = write_data;
    else if (!addr_is_zero)
      data = regs[addr];
  end
`else
  logic unused_bypass_inputs;
  assign unused_bypass_inputs = &{1'b0, reset, write_enable, write_address, write_data};

  always_comb begin
    data = '0;
    if (!addr_is_zero)
      data = regs[addr];
  end
`endif

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 RV32 register file, 2 async read ports, 1 sync write port; option REG_FILE_BYPASS_EN
module reg_file #(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] WRITE_DATA,
  output logic [DATA_WIDTH-1:0] DATA1,
  output logic [DATA_WIDTH-1:0] DATA2,
  input  logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
  input  logic [ADDR_WIDTH-1:0] DATA1_ADDRESS,
  input  logic [ADDR_WIDTH-1:0] DATA2_ADDRESS,
  input  logic                  WRITE_ENABLE,
  input  logic                  CLK,
  input  logic                  RESET
);
  import reg_file_pkg::*;

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  // Reset wins over a coincident write; x0 is never written so it stays zero
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      regs <= '0;
    else if (WRITE_ENABLE && (WRITE_ADDRESS != ADDR_WIDTH'(REG_ZERO)))
      regs[WRITE_ADDRESS] <= WRITE_DATA;
  end

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port1 (
    .regs          (regs),
    .addr          (DATA1_ADDRESS),
    .reset         (RESET),
    .write_enable  (WRITE_ENABLE),
    .write_address (WRITE_ADDRESS),
    .write_data    (WRITE_DATA),
    .data          (DATA1)
  );

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port2 (
    .regs          (regs),
    .addr          (DATA2_ADDRESS),
    .reset         (RESET),
    .write_enable  (WRITE_ENABLE),
    .write_address (WRITE_ADDRESS),
    .write_data    (WRITE_DATA),
    .data          (DATA2)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file (both REG_FILE_BYPASS_EN builds)
module tb_reg_file;

  logic [31:0] WRITE_DATA;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [4:0]  WRITE_ADDRESS;
  logic [4:0]  DATA1_ADDRESS;
  logic [4:0]  DATA2_ADDRESS;
  logic        WRITE_ENABLE;
  logic        CLK;
  logic        RESET;

  int tests_run = 0;
  int tests_failed = 0;
  bit cmp_en = 0;
  logic [31:0] model [32];

  reg_file dut (
    .WRITE_DATA    (WRITE_DATA),
    .DATA1         (DATA1),
    .DATA2         (DATA2),
    .WRITE_ADDRESS (WRITE_ADDRESS),
    .DATA1_ADDRESS (DATA1_ADDRESS),
    .DATA2_ADDRESS (DATA2_ADDRESS),
    .WRITE_ENABLE  (WRITE_ENABLE),
    .CLK           (CLK),
    .RESET         (RESET)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural model: reset clears everything, writes land on the edge unless to x0
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (WRITE_ENABLE === 1'b1 && WRITE_ADDRESS != 5'd0) begin
      model[WRITE_ADDRESS] = WRITE_DATA;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (RESET) return 32'h0;
    if (a == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (WRITE_ENABLE && WRITE_ADDRESS != 5'd0 && WRITE_ADDRESS == a) return WRITE_DATA;
`endif
    return model[a];
  endfunction

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("rand_data1", DATA1, exp_read(DATA1_ADDRESS));
      check("rand_data2", DATA2, exp_read(DATA2_ADDRESS));
    end
  end

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d, input logic en);
    @(negedge CLK);
    WRITE_ADDRESS = a;
    WRITE_DATA    = d;
    WRITE_ENABLE  = en;
    @(posedge CLK);
    #1;
    WRITE_ENABLE  = 1'b0;
  endtask

  task automatic read_both(input logic [4:0] a1, input logic [4:0] a2);
    DATA1_ADDRESS = a1;
    DATA2_ADDRESS = a2;
    #1;
  endtask

  logic [31:0] before_edge_exp;

  initial begin
    RESET = 1'b1;
    WRITE_DATA = '0;
    WRITE_ADDRESS = '0;
    DATA1_ADDRESS = '0;
    DATA2_ADDRESS = '0;
    WRITE_ENABLE = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset then read, while held and after release
    read_both(5'd0, 5'd1);
    check("rst_hold_a0", DATA1, 32'h0);
    check("rst_hold_a1", DATA2, 32'h0);
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    read_both(5'd31, 5'd1);
    check("rst_rel_a31", DATA1, 32'h0);
    check("rst_rel_a1", DATA2, 32'h0);

    // Basic write/read
    write_reg(5'd1, 32'd10, 1'b1);
    read_both(5'd1, 5'd0);
    check("wr_a1", DATA1, 32'd10);
    check("wr_x0_other", DATA2, 32'h0);

    // x0 protection
    write_reg(5'd0, 32'hDEADBEEF, 1'b1);
    read_both(5'd0, 5'd0);
    check("x0_p1", DATA1, 32'h0);
    check("x0_p2", DATA2, 32'h0);

    // Write-enable gating then enabled write, both ports on same register
    write_reg(5'd5, 32'h1234, 1'b0);
    read_both(5'd5, 5'd5);
    check("we0_a5", DATA1, 32'h0);
    write_reg(5'd5, 32'h1234, 1'b1);
    read_both(5'd5, 5'd5);
    check("we1_p1", DATA1, 32'h1234);
    check("we1_p2", DATA2, 32'h1234);

    // Same-cycle read and write of x7
    write_reg(5'd7, 32'd3, 1'b1);
    @(negedge CLK);
    WRITE_ADDRESS = 5'd7;
    WRITE_DATA    = 32'd9;
    WRITE_ENABLE  = 1'b1;
    read_both(5'd7, 5'd1);
`ifdef REG_FILE_BYPASS_EN
    before_edge_exp = 32'd9;
`else
    before_edge_exp = 32'd3;
`endif
    check("rw7_before", DATA1, before_edge_exp);
    check("rw7_other", DATA2, 32'd10);
    @(posedge CLK);
    #1;
    WRITE_ENABLE = 1'b0;
    check("rw7_after", DATA1, 32'd9);

    // Async reset between edges, plus a write attempted while reset is high
    write_reg(5'd31, 32'hFFFFFFFF, 1'b1);
    read_both(5'd31, 5'd7);
    check("a31_set", DATA1, 32'hFFFFFFFF);
    #1;
    RESET = 1'b1;
    #1;
    check("async_rst_a31", DATA1, 32'h0);
    check("async_rst_a7", DATA2, 32'h0);
    WRITE_ADDRESS = 5'd7;
    WRITE_DATA    = 32'h55;
    WRITE_ENABLE  = 1'b1;
    @(posedge CLK);
    #2;
    WRITE_ENABLE = 1'b0;
    RESET = 1'b0;
    #1;
    check("rst_prio_a7", DATA2, 32'h0);

    // Randomized run checked every cycle against the model
    @(posedge CLK);
    #2;
    cmp_en = 1;
    for (int n = 0; n < 600; n++) begin
      RESET         = ($urandom_range(0, 39) == 0);
      WRITE_ENABLE  = ($urandom_range(0, 3) != 0);
      WRITE_DATA    = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        WRITE_ADDRESS = 5'($urandom_range(0, 7));
        DATA1_ADDRESS = 5'($urandom_range(0, 7));
        DATA2_ADDRESS = 5'($urandom_range(0, 7));
      end else begin
        WRITE_ADDRESS = 5'($urandom_range(0, 31));
        DATA1_ADDRESS = 5'($urandom_range(0, 31));
        DATA2_ADDRESS = 5'($urandom_range(0, 31));
      end
      @(posedge CLK);
      #2;
    end
    cmp_en = 0;
    RESET = 1'b0;
    WRITE_ENABLE = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
